buffer_512_64_conv: RTL and testbench



---
 rtl/buffer_512_64_pkg.sv | 12 +
 rtl/buffer_512_64_conv.sv | 70 +++++++
 tb/tb_buffer_512_64_conv.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/buffer_512_64_pkg.sv
// Shared widths and word types for the 512-to-64 width-converting FIFO.
package buffer_512_64_pkg;

  localparam int unsigned IN_W      = 512;
  localparam int unsigned OUT_W     = 64;
  localparam int unsigned LANES     = IN_W / OUT_W;
  localparam int unsigned LANE_BITS = $clog2(LANES);

  typedef logic [IN_W-1:0]  t_in_word;
  typedef logic [OUT_W-1:0] t_out_word;

endpackage

// File: rtl/buffer_512_64_conv.sv
// Width-converting FIFO: 512-bit entries in, 64-bit lanes out, lowest lane first.
// The read port is first-word-fall-through.
module buffer_512_64_conv
  import buffer_512_64_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [IN_W-1:0]  data_in,
  input  logic             wr_enable,
  output logic [OUT_W-1:0] data_out,
  input  logic             rd_enable,
  output logic             full,
  output logic             empty,
  output logic             full_n
);

  localparam int unsigned NLANES = DEPTH * LANES;
  localparam int unsigned EW     = $clog2(DEPTH);
  localparam int unsigned LW     = $clog2(NLANES);
  localparam int unsigned CW     = LW + 1;

  logic [EW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  t_out_word     r_mem [NLANES];

  logic w_wr_ok;
  logic w_rd_ok;
  logic w_full;
  logic w_empty;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count > CW'(NLANES - LANES));
  assign w_wr_ok = wr_enable && !w_full;
  assign w_rd_ok = rd_enable && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + EW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + LW'(1);
      r_count <= r_count + (w_wr_ok ? CW'(LANES) : '0) - CW'(w_rd_ok);
    end
  end

  // Lane index is {entry, lane}, so the FWFT read pointer walks lanes 0..7 of each entry.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !clr && !rst) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        r_mem[{r_wr_ptr, LANE_BITS'(k)}] <= data_in[k*OUT_W +: OUT_W];
      end
    end
  end

  assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full     = w_full;
  assign full_n   = !w_full;
  assign empty    = w_empty;

endmodule

// File: tb/tb_buffer_512_64_conv.sv
// Self-checking bench for buffer_512_64_conv: a lane-queue model plus directed literal checks.
module tb_buffer_512_64_conv;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NL    = DEPTH * 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic [511:0] data_in = '0;
  logic         wr_enable = 1'b0;
  logic         rd_enable = 1'b0;
  logic [63:0]  data_out;
  logic         full, empty, full_n;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  bit          chk_en   = 1'b0;

  logic [63:0] mq[$];

  buffer_512_64_conv #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .data_in   (data_in),
    .wr_enable (wr_enable),
    .data_out  (data_out),
    .rd_enable (rd_enable),
    .full      (full),
    .empty     (empty),
    .full_n    (full_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model step at a rising edge, using the pre-edge queue occupancy.
  task automatic model_edge(output bit wr_ok, output bit rd_ok);
    wr_ok = 1'b0;
    rd_ok = 1'b0;
    if (rst || clr) begin
      mq.delete();
    end else begin
      wr_ok = wr_enable && !(mq.size() > NL - 8);
      rd_ok = rd_enable && (mq.size() != 0);
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) for (int k = 0; k < 8; k++) mq.push_back(data_in[k*64 +: 64]);
    end
  endtask

  task automatic tick(output bit wr_ok, output bit rd_ok);
    @(posedge clk);
    model_edge(wr_ok, rd_ok);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_empty",  {63'd0, empty},  {63'd0, mq.size() == 0});
      chk("m_full",   {63'd0, full},   {63'd0, mq.size() > NL - 8});
      chk("m_full_n", {63'd0, full_n}, {63'd0, !(mq.size() > NL - 8)});
      chk("m_data",   data_out, (mq.size() == 0) ? 64'h0 : mq[0]);
    end
  end

  function automatic logic [511:0] idx_word(input int unsigned w);
    logic [511:0] v;
    for (int k = 0; k < 8; k++) v[k*64 +: 64] = {32'(w), 32'(k)};
    return v;
  endfunction

  initial begin
    bit wo, ro;
    logic [63:0] lit [8];
    logic [511:0] wd;
    int unsigned n, pops, full_rises;
    logic [63:0] last;
    bit prev_full;

    lit[0] = 64'h0000_0000_0000_AAAA; lit[1] = 64'h1111_1111_1111_1111;
    lit[2] = 64'h2222_2222_2222_2222; lit[3] = 64'h3333_3333_3333_3333;
    lit[4] = 64'h4444_4444_4444_4444; lit[5] = 64'h5555_5555_5555_5555;
    lit[6] = 64'h6666_6666_6666_6666; lit[7] = 64'h7777_7777_7777_7777;

    // 1. reset values, no clock edge needed
    #2;
    rst = 1'b1;
    mq.delete();
    #1;
    chk("rst_empty",  {63'd0, empty},  64'd1);
    chk("rst_full",   {63'd0, full},   64'd0);
    chk("rst_full_n", {63'd0, full_n}, 64'd1);
    chk("rst_data",   data_out,        64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // 2. single word drain
    for (int k = 0; k < 8; k++) wd[k*64 +: 64] = lit[k];
    data_in = wd; wr_enable = 1'b1;
    tick(wo, ro);
    wr_enable = 1'b0; rd_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_lane%0d", k), data_out, lit[k]);
      tick(wo, ro);
    end
    chk("drain_empty", {63'd0, empty}, 64'd1);
    chk("drain_data0", data_out, 64'd0);
    rd_enable = 1'b0;

    // 3. fill and overflow
    for (int w = 1; w <= 5; w++) begin
      data_in = idx_word(w); wr_enable = 1'b1;
      tick(wo, ro);
      if (w == 4) begin
        chk("fill_full",   {63'd0, full},   64'd1);
        chk("fill_full_n", {63'd0, full_n}, 64'd0);
      end
    end
    wr_enable = 1'b0; rd_enable = 1'b1;
    pops = 0; last = '0;
    for (int c = 0; c < 40 && mq.size() != 0; c++) begin
      last = data_out;
      tick(wo, ro);
      if (ro) pops++;
    end
    chk("fill_pops", 64'(pops), 64'd32);
    chk("fill_last", last, 64'h0000_0004_0000_0007);
    rd_enable = 1'b0;

    // 4. underflow read together with a write
    chk("uf_pre_empty", {63'd0, empty}, 64'd1);
    data_in = idx_word(9); wr_enable = 1'b1; rd_enable = 1'b1;
    tick(wo, ro);
    wr_enable = 1'b0;
    chk("uf_lane0", data_out, 64'h0000_0009_0000_0000);
    for (int c = 0; c < 8; c++) tick(wo, ro);
    chk("uf_empty", {63'd0, empty}, 64'd1);
    rd_enable = 1'b0;

    // 5. steady streaming, incrementing lanes
    n = 0; full_rises = 0; prev_full = 1'b0;
    wr_enable = 1'b1; rd_enable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      for (int k = 0; k < 8; k++) wd[k*64 +: 64] = 64'(n * 8 + k);
      data_in = wd;
      tick(wo, ro);
      if (wo) n++;
      if (full && !prev_full) full_rises++;
      prev_full = full;
    end
    chk("stream_full_rises", 64'(full_rises > 0), 64'd1);
    wr_enable = 1'b0;
    last = '1;
    for (int c = 0; c < 40 && mq.size() != 0; c++) begin
      last = data_out;
      tick(wo, ro);
    end
    chk("stream_last", last, 64'(n * 8 - 1));
    chk("stream_empty", {63'd0, empty}, 64'd1);
    rd_enable = 1'b0;

    // 6a. clr with 3 lanes unread and a same-cycle write
    data_in = idx_word(20); wr_enable = 1'b1;
    tick(wo, ro);
    wr_enable = 1'b0; rd_enable = 1'b1;
    for (int c = 0; c < 5; c++) tick(wo, ro);
    chk("clr_pre_data", data_out, 64'h0000_0014_0000_0005);
    clr = 1'b1; wr_enable = 1'b1; data_in = idx_word(21);
    tick(wo, ro);
    clr = 1'b0; wr_enable = 1'b0;
    chk("clr_empty", {63'd0, empty}, 64'd1);
    chk("clr_data",  data_out, 64'd0);
    tick(wo, ro);
    chk("clr_stay_empty", {63'd0, empty}, 64'd1);
    rd_enable = 1'b0;

    // 6b. asynchronous reset between edges, write held across the reset edge
    data_in = idx_word(30); wr_enable = 1'b1;
    tick(wo, ro);
    wr_enable = 1'b0; rd_enable = 1'b1;
    for (int c = 0; c < 5; c++) tick(wo, ro);
    wr_enable = 1'b1; data_in = idx_word(31);
    #1;
    rst = 1'b1;
    mq.delete();
    #1;
    chk("arst_empty", {63'd0, empty}, 64'd1);
    chk("arst_data",  data_out, 64'd0);
    tick(wo, ro);
    rst = 1'b0; wr_enable = 1'b0;
    tick(wo, ro);
    chk("arst_stay_empty", {63'd0, empty}, 64'd1);
    rd_enable = 1'b0;
    tick(wo, ro);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
